// File: rtl/ppm_byte_assembler_if.sv
// ---------------------------------------------------------------------------
// ppm_byte_assembler_if
//
// Byte stream from the PPM byte assembler to the frame/CRC layer.
//
//   byte_data   head byte of the assembler FIFO (0 while empty)
//   byte_valid  FIFO holds at least one byte
//   byte_ready  consumer takes the head byte when byte_valid && byte_ready
//
// Modports:
//   master  producer side (ppm_byte_assembler)
//   slave   consumer side (frame/CRC layer)
// ---------------------------------------------------------------------------
interface ppm_byte_assembler_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/ppm_byte_assembler.sv
// ---------------------------------------------------------------------------
// ppm_byte_assembler
//
// Sits behind the PPM 1-of-4 symbol generator. Collects decoded 2-bit
// symbols while a frame is active, packs four of them (first symbol in the
// least significant pair) into a byte and queues the byte in a small FIFO
// that the frame/CRC layer drains over a valid/ready interface. End of frame
// is taken either from the frame-active signal falling or from a run of
// TIMEOUT_TICKS clk16 ticks without a captured symbol. A frame that ends on
// a partial byte raises frame_err; a byte that finds the FIFO full is
// dropped and raises overflow. Both flags are sticky until the next frame.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   clk16        single-cycle tick enable shared with the symbol generator
//   state_in     frame active (high from SOF detect)
//   sym_in       3'b0xx = symbol xx, 3'b1xx = no symbol
//   sym_done_in  symbol-complete level, held for a full clk16 period
//   bus          byte stream (master modport): byte_data/byte_valid/byte_ready
//   frame_end    one-cycle pulse at end of frame
//   frame_err    sticky, frame ended with a partial byte
//   overflow     sticky, a byte was dropped on a full FIFO
//   crc_ok       (PPM_CRC16_EN only) frame CRC residue matched, held to next frame
//
// Build option:
//   PPM_CRC16_EN  adds crc_ok and a CRC-16/ISO-15693 checker fed by every
//                 byte the packer produces (dropped bytes included).
//
// Parameters:
//   FIFO_DEPTH     byte FIFO entries, power of two, >= 2
//   TIMEOUT_TICKS  silent clk16 ticks in a frame before end of frame
// ---------------------------------------------------------------------------
module ppm_byte_assembler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_TICKS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk16,
  input  logic                 state_in,
  input  logic [2:0]           sym_in,
  input  logic                 sym_done_in,
  ppm_byte_assembler_if.master bus,
  output logic                 frame_end,
  output logic                 frame_err,
  output logic                 overflow
`ifdef PPM_CRC16_EN
  ,
  output logic                 crc_ok
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        st;
  logic          state_in_q;
  logic [1:0]    sym_cnt;
  logic [5:0]    shift;
  logic [TW-1:0] timeout;

  logic          sym_take;
  logic [1:0]    cnt_nxt;
  logic [TW-1:0] tmo_nxt;
  logic          in_rise;
  logic          in_fall;
  logic          end_frame;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          push_drop;
  logic [7:0]    push_byte;

`ifdef PPM_CRC16_EN
  logic [15:0]   crc;
  logic [15:0]   crc_nxt;

  // Reflected CRC-16 (poly 0x8408), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Symbol capture and packing
  // -------------------------------------------------------------------------
  // sym_done_in is a level held for a whole clk16 period, so qualifying it
  // with the tick yields exactly one capture per symbol.
  assign sym_take  = clk16 && sym_done_in && !sym_in[2] && (st == S_RECV);
  assign cnt_nxt   = sym_take ? (sym_cnt + 2'd1) : sym_cnt;
  assign push      = sym_take && (sym_cnt == 2'd3);
  // The fourth symbol bypasses the shift register and goes straight out.
  assign push_byte = {sym_in[1:0], shift};

  assign in_rise   = state_in && !state_in_q;
  assign in_fall   = !state_in && state_in_q;

  // Silence counter: a capture always wins over an expiring tick.
  always_comb begin
    tmo_nxt = timeout;
    if (sym_take)
      tmo_nxt = '0;
    else if (clk16 && (timeout != TMO_MAX))
      tmo_nxt = timeout + TW'(1);
  end

  // Timeout and a falling frame-active in the same cycle collapse into one
  // DONE entry.
  assign end_frame = (st == S_RECV) && (in_fall || (tmo_nxt == TMO_MAX));

  // -------------------------------------------------------------------------
  // Byte FIFO
  // -------------------------------------------------------------------------
  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = bus.byte_valid && bus.byte_ready;
  // A pop in the same cycle frees the slot a push on a full FIFO needs.
  assign push_ok    = push && (!fifo_full || pop);
  assign push_drop  = push && fifo_full && !pop;

  assign bus.byte_valid = !fifo_empty;
  assign bus.byte_data  = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= push_byte;
  end

`ifdef PPM_CRC16_EN
  // Every byte the packer emits is folded in, whether or not the FIFO kept it.
  always_comb begin
    crc_nxt = crc;
    if (push)
      crc_nxt = crc16_byte(crc, push_byte);
  end
`endif

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      state_in_q <= 1'b0;
      sym_cnt    <= 2'd0;
      shift      <= 6'd0;
      timeout    <= '0;
      frame_end  <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
`ifdef PPM_CRC16_EN
      crc        <= 16'hFFFF;
      crc_ok     <= 1'b0;
`endif
    end else begin
      state_in_q <= state_in;
      frame_end  <= 1'b0;
      if (push_drop)
        overflow <= 1'b1;

      unique case (st)
        S_IDLE: begin
          if (in_rise) begin
            st        <= S_RECV;
            sym_cnt   <= 2'd0;
            shift     <= 6'd0;
            timeout   <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
`ifdef PPM_CRC16_EN
            crc       <= 16'hFFFF;
            crc_ok    <= 1'b0;
`endif
          end
        end

        S_RECV: begin
          timeout <= tmo_nxt;
          sym_cnt <= cnt_nxt;
          if (sym_take) begin
            case (sym_cnt)
              2'd0:    shift[1:0] <= sym_in[1:0];
              2'd1:    shift[3:2] <= sym_in[1:0];
              2'd2:    shift[5:4] <= sym_in[1:0];
              default: shift      <= 6'd0;
            endcase
          end
`ifdef PPM_CRC16_EN
          crc <= crc_nxt;
`endif
          // Flags are registered on DONE entry so they line up with
          // frame_end; cnt_nxt includes a capture landing this same cycle.
          if (end_frame) begin
            st        <= S_DONE;
            frame_end <= 1'b1;
            if (cnt_nxt != 2'd0)
              frame_err <= 1'b1;
`ifdef PPM_CRC16_EN
            crc_ok    <= (crc_nxt == 16'hF0B8) &&
                         !(frame_err || (cnt_nxt != 2'd0));
`endif
          end
        end

        S_DONE: begin
          // Any partial byte is discarded here.
          st      <= S_IDLE;
          sym_cnt <= 2'd0;
          shift   <= 6'd0;
          timeout <= '0;
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_byte_assembler.sv
// ---------------------------------------------------------------------------
// tb_ppm_byte_assembler
//
// Drives the assembler the way the symbol generator does (clk16 tick every
// DIV clocks, sym_done_in held for the whole tick period) and keeps a
// reference model of the frame: symbols accumulated four to a byte, a
// bounded byte queue standing in for the FIFO, and the expected sticky flags.
// ---------------------------------------------------------------------------
module tb_ppm_byte_assembler;

  localparam int FIFO_DEPTH    = 4;
  localparam int TIMEOUT_TICKS = 24;
  localparam int DIV           = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk16;
  logic       state_in;
  logic [2:0] sym_in;
  logic       sym_done_in;
  logic       frame_end;
  logic       frame_err;
  logic       overflow;
`ifdef PPM_CRC16_EN
  logic       crc_ok;
`endif

  ppm_byte_assembler_if bus ();

  ppm_byte_assembler #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk16       (clk16),
    .state_in    (state_in),
    .sym_in      (sym_in),
    .sym_done_in (sym_done_in),
    .bus         (bus),
    .frame_end   (frame_end),
    .frame_err   (frame_err),
    .overflow    (overflow)
`ifdef PPM_CRC16_EN
    ,
    .crc_ok      (crc_ok)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fe_pulses = 0;

  // Reference model
  logic [7:0] mq[$];
  int         m_cnt;
  logic [7:0] m_acc;
  logic       m_ovf;

  always @(negedge clk)
    if (frame_end === 1'b1)
      fe_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < FIFO_DEPTH)
      mq.push_back(b);
    else
      m_ovf = 1'b1;
  endtask

  // One generator symbol period; the tick lands on the last clock.
  task automatic send_sym(input logic [2:0] code, input bit pop_on_tick);
    for (int i = 0; i < DIV; i++) begin
      sym_in         = code;
      sym_done_in    = 1'b1;
      clk16          = (i == DIV - 1);
      bus.byte_ready = pop_on_tick && (i == DIV - 1);
      if (bus.byte_ready) begin
        checks++;
        if (bus.byte_valid !== 1'b1 || mq.size() == 0 || bus.byte_data !== mq[0])
          $display("FAIL pop_on_tick got valid=%0b data=%02h exp head=%02h",
                   bus.byte_valid, bus.byte_data, (mq.size() != 0) ? mq[0] : 8'h00);
        else
          errors = errors;
        if (bus.byte_valid !== 1'b1 || mq.size() == 0 || bus.byte_data !== mq[0])
          errors++;
        if (mq.size() != 0)
          void'(mq.pop_front());
      end
      cycle();
    end
    clk16          = 1'b0;
    sym_done_in    = 1'b0;
    bus.byte_ready = 1'b0;
    if (!code[2]) begin
      m_acc = m_acc | (8'(code[1:0]) << (2 * m_cnt));
      m_cnt++;
      if (m_cnt == 4) begin
        model_push(m_acc);
        m_acc = 8'h00;
        m_cnt = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop_last);
    send_sym({1'b0, b[1:0]}, 1'b0);
    send_sym({1'b0, b[3:2]}, 1'b0);
    send_sym({1'b0, b[5:4]}, 1'b0);
    send_sym({1'b0, b[7:6]}, pop_last);
  endtask

  task automatic start_frame();
    state_in    = 1'b0;
    clk16       = 1'b0;
    sym_done_in = 1'b0;
    sym_in      = 3'b100;
    repeat (3) cycle();
    state_in = 1'b1;
    cycle();
    m_cnt = 0;
    m_acc = 8'h00;
    m_ovf = 1'b0;
    checks++;
    if (frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL start_clear got err=%0b ovf=%0b exp 0 0", frame_err, overflow);
    end
`ifdef PPM_CRC16_EN
    checks++;
    if (crc_ok !== 1'b0) begin
      errors++;
      $display("FAIL start_crc_clear got %0b exp 0", crc_ok);
    end
`endif
  endtask

  task automatic end_by_fall();
    state_in = 1'b0;
    cycle();
    checks++;
    if (frame_end !== 1'b1) begin
      errors++;
      $display("FAIL fall_frame_end got %0b exp 1", frame_end);
    end
    checks++;
    if (frame_err !== (m_cnt != 0)) begin
      errors++;
      $display("FAIL fall_frame_err got %0b exp %0b", frame_err, (m_cnt != 0));
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL fall_overflow got %0b exp %0b", overflow, m_ovf);
    end
    m_cnt = 0;
    m_acc = 8'h00;
    cycle();
    checks++;
    if (frame_end !== 1'b0) begin
      errors++;
      $display("FAIL fall_pulse_width got %0b exp 0", frame_end);
    end
  endtask

  task automatic end_by_timeout();
    int seen_at;
    int idx;
    seen_at     = -1;
    idx         = 0;
    sym_done_in = 1'b0;
    for (int t = 0; t < TIMEOUT_TICKS + 2 && seen_at < 0; t++) begin
      for (int i = 0; i < DIV; i++) begin
        clk16 = (i == DIV - 1);
        cycle();
        if (frame_end === 1'b1 && seen_at < 0) begin
          seen_at = idx;
          checks++;
          if (frame_err !== (m_cnt != 0)) begin
            errors++;
            $display("FAIL tmo_frame_err got %0b exp %0b", frame_err, (m_cnt != 0));
          end
          checks++;
          if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL tmo_overflow got %0b exp %0b", overflow, m_ovf);
          end
        end
        idx++;
      end
    end
    clk16 = 1'b0;
    checks++;
    if (seen_at != TIMEOUT_TICKS * DIV - 1) begin
      errors++;
      $display("FAIL tmo_latency got cycle %0d exp cycle %0d", seen_at, TIMEOUT_TICKS * DIV - 1);
    end
    cycle();
    checks++;
    if (frame_end !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_width got %0b exp 0", frame_end);
    end
    m_cnt = 0;
    m_acc = 8'h00;
  endtask

  // Pops n bytes with a random ready pattern, checking order and hold.
  task automatic drain(input int n);
    int         got;
    int         guard;
    bit         held;
    logic [7:0] held_data;
    got   = 0;
    guard = 0;
    while (got < n && guard < 200) begin
      bus.byte_ready = ($urandom_range(0, 2) != 0);
      if (bus.byte_ready && bus.byte_valid === 1'b1) begin
        checks++;
        if (bus.byte_data !== mq[0]) begin
          errors++;
          $display("FAIL drain_data got %02h exp %02h", bus.byte_data, mq[0]);
        end
        void'(mq.pop_front());
        got++;
      end
      held      = (bus.byte_valid === 1'b1) && !bus.byte_ready;
      held_data = bus.byte_data;
      cycle();
      guard++;
      if (held) begin
        checks++;
        if (bus.byte_data !== held_data) begin
          errors++;
          $display("FAIL drain_hold got %02h exp %02h", bus.byte_data, held_data);
        end
      end
    end
    bus.byte_ready = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL drain_count got %0d exp %0d", got, n);
    end
    checks++;
    if (bus.byte_valid !== (mq.size() != 0)) begin
      errors++;
      $display("FAIL drain_valid got %0b exp %0b", bus.byte_valid, (mq.size() != 0));
    end
  endtask

  task automatic test_reset();
    cycle();
    checks++;
    if (bus.byte_valid !== 1'b0 || bus.byte_data !== 8'h00 || frame_end !== 1'b0 ||
        frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_init got v=%0b d=%02h fe=%0b err=%0b ovf=%0b exp all 0",
               bus.byte_valid, bus.byte_data, frame_end, frame_err, overflow);
    end
    rst = 1'b0;
    cycle();
    start_frame();
    for (int s = 0; s < 8; s++)
      send_sym({1'b0, 2'($urandom)}, 1'b0);
    send_sym({1'b0, 2'($urandom)}, 1'b0);
    checks++;
    if (bus.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup_valid got %0b exp 1", bus.byte_valid);
    end
    rst      = 1'b1;
    state_in = 1'b0;
    #2;
    checks++;
    if (bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_flush got %0b exp 0", bus.byte_valid);
    end
    cycle();
    checks++;
    if (bus.byte_valid !== 1'b0 || bus.byte_data !== 8'h00 || frame_end !== 1'b0 ||
        frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame got v=%0b d=%02h fe=%0b err=%0b ovf=%0b exp all 0",
               bus.byte_valid, bus.byte_data, frame_end, frame_err, overflow);
    end
    mq.delete();
    m_cnt = 0;
    m_acc = 8'h00;
    m_ovf = 1'b0;
    rst   = 1'b0;
    cycle();
  endtask

  task automatic test_basic_packing();
    start_frame();
    send_sym(3'b001, 1'b0);
    send_sym(3'b111, 1'b0);
    send_sym(3'b000, 1'b0);
    send_sym(3'b011, 1'b0);
    checks++;
    if (bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL pack_early_valid got %0b exp 0", bus.byte_valid);
    end
    send_sym(3'b010, 1'b0);
    checks++;
    if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'hB1) begin
      errors++;
      $display("FAIL pack_byte got v=%0b d=%02h exp v=1 d=b1", bus.byte_valid, bus.byte_data);
    end
    bus.byte_ready = 1'b1;
    cycle();
    bus.byte_ready = 1'b0;
    if (mq.size() != 0)
      void'(mq.pop_front());
    checks++;
    if (bus.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL pack_pop got %0b exp 0", bus.byte_valid);
    end
    end_by_fall();
  endtask

  task automatic test_timeout();
    start_frame();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    end_by_timeout();
    checks++;
    if (mq.size() != 2) begin
      errors++;
      $display("FAIL tmo_model_queue got %0d exp 2", mq.size());
    end
    drain(2);
  endtask

  task automatic test_partial();
    start_frame();
    for (int s = 0; s < 6; s++)
      send_sym({1'b0, 2'($urandom)}, 1'b0);
    end_by_fall();
    drain(1);
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    start_frame();
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      send_byte(b, 1'b0);
      checks++;
      if (overflow !== (k == 4)) begin
        errors++;
        $display("FAIL ovf_byte%0d got %0b exp %0b", k, overflow, (k == 4));
      end
    end
    end_by_fall();
    drain(4);
    start_frame();
    for (int k = 0; k < 4; k++)
      send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b1);
    checks++;
    if (overflow !== 1'b0 || bus.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop got ovf=%0b v=%0b exp ovf=0 v=1", overflow, bus.byte_valid);
    end
    end_by_fall();
    drain(4);
  endtask

  task automatic test_capture_vs_timeout();
    int fe0;
    start_frame();
    fe0 = fe_pulses;
    send_sym({1'b0, 2'($urandom)}, 1'b0);
    for (int t = 0; t < TIMEOUT_TICKS - 1; t++)
      send_sym({1'b1, 2'($urandom)}, 1'b0);
    send_sym({1'b0, 2'($urandom)}, 1'b0);
    checks++;
    if (fe_pulses != fe0) begin
      errors++;
      $display("FAIL capture_wins got %0d pulses exp 0", fe_pulses - fe0);
    end
    end_by_fall();
  endtask

`ifdef PPM_CRC16_EN
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ d[i]) == 1'b1)
        r = (r >> 1) ^ 16'h8408;
      else
        r = r >> 1;
    end
    return r;
  endfunction

  task automatic test_crc();
    logic [15:0] c;
    logic [15:0] fcs;
    c   = 16'hFFFF;
    c   = ref_crc(c, 8'h01);
    c   = ref_crc(c, 8'h02);
    fcs = ~c;
    start_frame();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(fcs[7:0], 1'b0);
    send_byte(fcs[15:8], 1'b0);
    end_by_fall();
    checks++;
    if (crc_ok !== 1'b1) begin
      errors++;
      $display("FAIL crc_good got %0b exp 1", crc_ok);
    end
    drain(4);
    checks++;
    if (crc_ok !== 1'b1) begin
      errors++;
      $display("FAIL crc_hold got %0b exp 1", crc_ok);
    end
    start_frame();
    send_byte(8'h05, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(fcs[7:0], 1'b0);
    send_byte(fcs[15:8], 1'b0);
    end_by_fall();
    checks++;
    if (crc_ok !== 1'b0) begin
      errors++;
      $display("FAIL crc_corrupt got %0b exp 0", crc_ok);
    end
    drain(4);
  endtask
`endif

  task automatic test_random_frames();
    int nsym;
    for (int f = 0; f < 8; f++) begin
      start_frame();
      nsym = $urandom_range(1, 22);
      for (int s = 0; s < nsym; s++) begin
        if ($urandom_range(0, 5) == 0)
          send_sym({1'b1, 2'($urandom)}, 1'b0);
        send_sym({1'b0, 2'($urandom)}, 1'b0);
      end
      if ($urandom_range(0, 1) == 1)
        end_by_fall();
      else
        end_by_timeout();
      drain($urandom_range(0, mq.size()));
    end
    drain(mq.size());
  endtask

  initial begin
    rst            = 1'b1;
    clk16          = 1'b0;
    state_in       = 1'b0;
    sym_in         = 3'b100;
    sym_done_in    = 1'b0;
    bus.byte_ready = 1'b0;
    m_cnt          = 0;
    m_acc          = 8'h00;
    m_ovf          = 1'b0;
    test_reset();
    test_basic_packing();
    test_timeout();
    test_partial();
    test_overflow();
    test_capture_vs_timeout();
`ifdef PPM_CRC16_EN
    test_crc();
`endif
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
